// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: default sizes, select-width helper, FSM states.
// The optional per-port beat counters are enabled by defining STREAM_DEMUX_CNT_EN.
package stream_demux_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_N_OUT  = 4;
    localparam int CNT_W          = 16;

    // A select bus is at least one bit wide, even for a two-port demux.
    function automatic int sel_width(input int n_out);
        return (n_out <= 2) ? 1 : $clog2(n_out);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/demux_out_reg.sv
// Single output register stage of the demux: holds one beat plus its destination port,
// loads and drains in the same cycle so a sink that is always ready sees no bubbles.
module demux_out_reg
    import stream_demux_pkg::*;
#(
    parameter int   DATA_W = DEFAULT_DATA_W,
    parameter int   N_OUT  = DEFAULT_N_OUT,
    localparam int  SEL_W  = sel_width(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic [SEL_W-1:0]  load_dest,
    input  logic [N_OUT-1:0]  m_ready,
    output logic              ready,
    output logic [N_OUT-1:0]  m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    logic              valid_reg, valid_next;
    logic [SEL_W-1:0]  dest_reg,  dest_next;
    logic [DATA_W-1:0] data_reg,  data_next;
    logic              last_reg,  last_next;
    logic              drain;

    // Only the current destination's ready matters; other ports' ready bits are ignored.
    assign drain = valid_reg & m_ready[dest_reg];
    assign ready = !valid_reg | m_ready[dest_reg];

    always_comb begin
        valid_next = valid_reg;
        dest_next  = dest_reg;
        data_next  = data_reg;
        last_next  = last_reg;
        if (load) begin
            valid_next = 1'b1;
            dest_next  = load_dest;
            data_next  = load_data;
            last_next  = load_last;
        end else if (drain) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            dest_reg  <= '0;
            data_reg  <= '0;
            last_reg  <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            dest_reg  <= dest_next;
            data_reg  <= data_next;
            last_reg  <= last_next;
        end
    end

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_valid
            assign m_valid[gi] = valid_reg && (dest_reg == SEL_W'(gi));
        end
    endgenerate

    assign m_data = data_reg;
    assign m_last = last_reg;

endmodule

// File: rtl/stream_demux.sv
// 1-to-N_OUT packet demultiplexer: destination sampled on a packet's first beat and locked
// until its last beat. Define STREAM_DEMUX_CNT_EN to add per-port 16-bit delivered-beat counters.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int   DATA_W = DEFAULT_DATA_W,
    parameter int   N_OUT  = DEFAULT_N_OUT,
    localparam int  SEL_W  = sel_width(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    input  logic [SEL_W-1:0]       s_sel,
    input  logic                   s_last,
    output logic [N_OUT-1:0]       m_valid,
    input  logic [N_OUT-1:0]       m_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_last,
    output logic [N_OUT*CNT_W-1:0] beat_cnt
);

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] lock_dest_reg, lock_dest_next;
    logic [SEL_W-1:0] sel_clamped;
    logic [SEL_W-1:0] dest;
    logic             accept;

    // Out-of-range selects fall onto the highest port.
    generate
        if (N_OUT == (1 << SEL_W)) begin : g_sel_full
            assign sel_clamped = s_sel;
        end else begin : g_sel_clamp
            localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(N_OUT - 1);
            assign sel_clamped = (s_sel > MAX_SEL) ? MAX_SEL : s_sel;
        end
    endgenerate

    assign accept = s_valid & s_ready;
    assign dest   = (state_reg == BUSY) ? lock_dest_reg : sel_clamped;

    always_comb begin
        state_next     = state_reg;
        lock_dest_next = lock_dest_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    lock_dest_next = sel_clamped;
                    if (!s_last) begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (accept && s_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lock_dest_reg <= '0;
        end else begin
            state_reg     <= state_next;
            lock_dest_reg <= lock_dest_next;
        end
    end

    demux_out_reg #(
        .DATA_W (DATA_W),
        .N_OUT  (N_OUT)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (s_data),
        .load_last (s_last),
        .load_dest (dest),
        .m_ready   (m_ready),
        .ready     (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last)
    );

`ifdef STREAM_DEMUX_CNT_EN
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (m_valid[gi] && m_ready[gi]) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            assign beat_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate
`else
    assign beat_cnt = '0;
`endif

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload width in bits.
REQ-002 SHALL have parameter N_OUT, default 4, meaning number of output ports (2..8); SEL_W = $clog2(N_OUT).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_valid  input  1  upstream beat valid.
REQ-006 SHALL have port s_ready  output  1  upstream beat accepted when s_valid & s_ready.
REQ-007 SHALL have port s_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port s_sel  input  SEL_W  destination port index, sampled on the first beat of a packet.
REQ-009 SHALL have port s_last  input  1  final beat of a packet.
REQ-010 SHALL have port m_valid  output  N_OUT  one-hot per-port beat valid.
REQ-011 SHALL have port m_ready  input  N_OUT  per-port downstream ready.
REQ-012 SHALL have port m_data  output  DATA_W  shared registered payload to all ports.
REQ-013 SHALL have port m_last  output  1  shared registered last flag.
REQ-014 SHALL have port beat_cnt  output  N_OUT*16  per-port delivered-beat counters (see Configuration).

Function
REQ-015 SHALL be a 1-to-N_OUT packet demultiplexer with a single output register stage, latency exactly 1 cycle from acceptance to m_valid.
REQ-016 SHALL implement FSM IDLE/BUSY: IDLE->BUSY on an accepted beat with s_last=0; BUSY->IDLE on an accepted beat with s_last=1; IDLE->IDLE on an accepted single-beat packet.
REQ-017 SHALL use s_sel as destination in IDLE and a locked destination register (captured at the first accepted beat) in BUSY; s_sel is ignored in BUSY.
REQ-018 SHALL drive s_ready = !out_v | m_ready[out_dest], where out_v/out_dest describe the output register; s_ready is independent of s_valid.
REQ-019 SHALL assert at most one m_valid bit, bit out_dest, and only while out_v=1.
REQ-020 SHALL sustain one beat per cycle when the destination sink holds m_ready=1.
REQ-021 SHALL hold m_data, m_last, m_valid stable while m_valid[out_dest]=1 and m_ready[out_dest]=0.
REQ-022 SHALL, on simultaneous drain and accept, load the new beat in the same cycle (no bubble), including a destination change between packets.
REQ-023 SHALL treat s_sel >= N_OUT as destination N_OUT-1 (clamped).
REQ-024 SHALL ignore m_ready bits of non-destination ports.

Reset
REQ-025 SHALL, on rst_n=0, immediately force FSM=IDLE, out_v=0, m_valid=0, m_data=0, m_last=0, locked destination=0, beat_cnt=0; s_ready=1 after reset.
REQ-026 SHALL discard any in-flight beat and partial packet on reset mid-packet; the first beat after release is a new packet header.

Configuration
REQ-027 SHALL with macro STREAM_DEMUX_CNT_EN defined implement one 16-bit wrapping counter per port, incremented on each m_valid[i]&m_ready[i].
REQ-028 SHALL with STREAM_DEMUX_CNT_EN undefined tie beat_cnt to 0 and instantiate no counter flops.

Structure
REQ-029 SHALL place default DATA_W, N_OUT, the SEL_W function and the IDLE/BUSY state enum in package stream_demux_pkg.
REQ-030 SHALL implement the output register as sub-module demux_out_reg (payload, last, valid, dest, load/drain control).

Verification
REQ-031 SHALL cover: reset, 3-beat packet sel=2 data 0x11,0x22,0x33 with all m_ready=1 -> m_valid=4'b0100 on cycles 1..3, m_last only with 0x33.
REQ-032 SHALL cover: s_sel changed to 0 mid-packet (sel=3 locked) -> all beats still on port 3.
REQ-033 SHALL cover: m_ready[1]=0 for 4 cycles with beat 0xA5 pending -> s_ready=0, m_data=0xA5 stable, delivered once after m_ready[1]=1.
REQ-034 SHALL cover: back-to-back single-beat packets to ports 0,1,2,3 -> one beat per cycle, no bubbles, correct one-hot m_valid.
REQ-035 SHALL cover: rst_n pulsed low during beat 2 of 4 -> m_valid=0 immediately, next beat routed by fresh s_sel.
REQ-036 SHALL cover: with STREAM_DEMUX_CNT_EN, 65537 beats to port 0 -> beat_cnt[15:0]=1; without it beat_cnt=0.
